// File: rtl/alu_operand_issue_pkg.sv
// Shared definitions for the ALU operand issue stage.
//   DATA_WIDTH : operand/result width
//   REG_AW     : register index width (x0..x31)
//   alu_op_e   : ALU operation codes; ALU_NOP marks a bubble
//   fwd_hit    : true when a write-back source targets a non-x0 register
package alu_operand_issue_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_AW     = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_NOP  = 4'hF
    } alu_op_e;

    // x0 is hard-wired to zero, so it never matches a producer.
    function automatic logic fwd_hit(
        input logic              wr,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] src
    );
        return wr && (rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/alu_operand_issue_fwd_mux.sv
// Operand forwarding mux (combinational).
//   addr            : source register index
//   rf_data         : register file read value
//   exm_*           : EX/MEM producer (highest priority)
//   wb_*            : WB producer
//   data            : resolved operand value
module operand_fwd_mux
    import alu_operand_issue_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DW-1:0]     rf_data,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DW-1:0]     exm_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DW-1:0]     wb_data,
    output logic [DW-1:0]     data
);

    always_comb begin
        data = rf_data;
        if (fwd_hit(exm_reg_write, exm_rd_addr, addr)) begin
            data = exm_data;
        end else if (fwd_hit(wb_reg_write, wb_rd_addr, addr)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_issue.sv
// ID/EX issue stage in front of the ALU.
//   in_*     : decoded instruction, valid/ready handshake (in_ready combinational)
//   exm_*    : EX/MEM in-flight result (forward source, load-use detection)
//   wb_*     : WB in-flight result (forward source)
//   flush    : squash held and incoming instruction
//   out_*    : registered operands/control for the ALU, valid/ready handshake
module alu_operand_issue
    import alu_operand_issue_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_pc,
    input  logic [DW-1:0]     in_rs1_data,
    input  logic [DW-1:0]     in_rs2_data,
    input  logic [DW-1:0]     in_imm,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic              in_rs1_used,
    input  logic              in_rs2_used,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_reg_write,
    input  logic [3:0]        in_alu_sel,
    input  logic              in_a_sel,
    input  logic              in_b_sel,
    input  logic              exm_reg_write,
    input  logic              exm_is_load,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [DW-1:0]     exm_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DW-1:0]     wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_a,
    output logic [DW-1:0]     out_b,
    output logic [3:0]        out_alu_sel,
    output logic [DW-1:0]     out_rs2_fwd,
    output logic [DW-1:0]     out_pc,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write
);

    logic [DW-1:0] rs1_fwd;
    logic [DW-1:0] rs2_fwd;
    logic [DW-1:0] a_next;
    logic [DW-1:0] b_next;
    logic          load_use;
    logic          accept;

    operand_fwd_mux #(.DW(DW)) u_fwd_rs1 (
        .addr          (in_rs1_addr),
        .rf_data       (in_rs1_data),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_data      (exm_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .data          (rs1_fwd)
    );

    operand_fwd_mux #(.DW(DW)) u_fwd_rs2 (
        .addr          (in_rs2_addr),
        .rf_data       (in_rs2_data),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_data      (exm_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .data          (rs2_fwd)
    );

    // A load in EX/MEM has no data yet; a dependent instruction must wait a cycle.
    always_comb begin
        load_use = 1'b0;
        if (in_valid && exm_is_load) begin
            load_use = (in_rs1_used && fwd_hit(exm_reg_write, exm_rd_addr, in_rs1_addr)) ||
                       (in_rs2_used && fwd_hit(exm_reg_write, exm_rd_addr, in_rs2_addr));
        end
    end

    always_comb begin
        a_next = in_a_sel ? in_pc  : rs1_fwd;
        b_next = in_b_sel ? in_imm : rs2_fwd;
    end

    assign in_ready = (!out_valid || out_ready) && !load_use;
    assign accept   = in_valid && in_ready;

    // Bubbles clear only the control fields; data fields keep their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_a         <= '0;
            out_b         <= '0;
            out_rs2_fwd   <= '0;
            out_pc        <= '0;
            out_alu_sel   <= ALU_NOP;
            out_rd_addr   <= '0;
            out_reg_write <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_alu_sel   <= ALU_NOP;
            out_reg_write <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_a         <= a_next;
            out_b         <= b_next;
            out_rs2_fwd   <= rs2_fwd;
            out_pc        <= in_pc;
            out_alu_sel   <= in_alu_sel;
            out_rd_addr   <= in_rd_addr;
            out_reg_write <= in_reg_write;
        end else if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
            out_alu_sel   <= ALU_NOP;
            out_reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;
    import alu_operand_issue_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_rs1_used, in_rs2_used, in_reg_write;
    logic [3:0]  in_alu_sel;
    logic        in_a_sel, in_b_sel;
    logic        exm_reg_write, exm_is_load;
    logic [4:0]  exm_rd_addr;
    logic [31:0] exm_data;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b, out_rs2_fwd, out_pc;
    logic [3:0]  out_alu_sel;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_operand_issue #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_alu_sel(in_alu_sel),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
        .exm_rd_addr(exm_rd_addr), .exm_data(exm_data),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_sel(out_alu_sel),
        .out_rs2_fwd(out_rs2_fwd), .out_pc(out_pc),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every beat the ALU consumes is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: a=0x%0h b=0x%0h pc=0x%0h, none expected",
                         out_a, out_b, out_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (out_a !== e.a || out_b !== e.b || out_rs2_fwd !== e.rs2 || out_pc !== e.pc ||
                    out_alu_sel !== e.sel || out_rd_addr !== e.rd || out_reg_write !== e.wr) begin
                    n_fail++;
                    $display("FAIL issue_pc%0h: got a=%0h b=%0h rs2=%0h pc=%0h sel=%0h rd=%0d wr=%0b expected a=%0h b=%0h rs2=%0h pc=%0h sel=%0h rd=%0d wr=%0b",
                             e.pc, out_a, out_b, out_rs2_fwd, out_pc, out_alu_sel, out_rd_addr, out_reg_write,
                             e.a, e.b, e.rs2, e.pc, e.sel, e.rd, e.wr);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd, input logic wr,
                         input logic [3:0] sel, input logic asel, input logic bsel);
        in_pc = pc; in_rs1_data = rs1d; in_rs2_data = rs2d; in_imm = imm;
        in_rs1_addr = rs1; in_rs2_addr = rs2; in_rs1_used = u1; in_rs2_used = u2;
        in_rd_addr = rd; in_reg_write = wr; in_alu_sel = sel; in_a_sel = asel; in_b_sel = bsel;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for the handshake, record the expectation, then drop in_valid.
    task automatic issue(input exp_t e);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout_pc%0h: in_ready stayed 0, expected 1", e.pc);
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t x;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        exm_reg_write = 0; exm_is_load = 0; exm_rd_addr = 0; exm_data = 0;
        wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0);
        in_valid = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_alu_sel", {28'b0, out_alu_sel}, {28'b0, ALU_NOP});
        check("rst_reg_write", {31'b0, out_reg_write}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_out_a", out_a, 0);
        check("rst_out_pc", out_pc, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // EX/MEM beats WB on rs1; rs2 untouched
        exm_reg_write = 1; exm_rd_addr = 5; exm_data = 32'h11;
        wb_reg_write = 1;  wb_rd_addr = 5;  wb_data = 32'h22;
        drive(32'h10, 32'hAAAA, 32'h33, 0, 5, 3, 1, 1, 10, 1, ALU_ADD, 0, 0);
        issue('{a:32'h11, b:32'h33, rs2:32'h33, pc:32'h10, sel:ALU_ADD, rd:10, wr:1});
        exm_reg_write = 0;
        drive(32'h14, 32'hAAAA, 32'h33, 0, 5, 3, 1, 1, 11, 1, ALU_XOR, 0, 0);
        issue('{a:32'h22, b:32'h33, rs2:32'h33, pc:32'h14, sel:ALU_XOR, rd:11, wr:1});

        // x0 never forwarded
        exm_reg_write = 1; exm_rd_addr = 0; exm_data = 32'hDEAD;
        wb_reg_write = 1;  wb_rd_addr = 0;  wb_data = 32'hBEEF;
        drive(32'h18, 32'h44, 0, 0, 4, 0, 1, 1, 12, 1, ALU_OR, 0, 0);
        issue('{a:32'h44, b:32'h0, rs2:32'h0, pc:32'h18, sel:ALU_OR, rd:12, wr:1});

        // PC/imm select, rs2 still forwarded for store data
        exm_reg_write = 0;
        wb_reg_write = 1; wb_rd_addr = 6; wb_data = 32'h606;
        drive(32'h100, 32'h1, 32'h66, 32'hFFFFFFFC, 1, 6, 1, 1, 13, 1, ALU_ADD, 1, 1);
        issue('{a:32'h100, b:32'hFFFFFFFC, rs2:32'h606, pc:32'h100, sel:ALU_ADD, rd:13, wr:1});
        wb_reg_write = 0;

        // Load-use: one stall cycle, bubble, then accept with forwarded load data
        exm_reg_write = 1; exm_is_load = 1; exm_rd_addr = 7; exm_data = 32'h0;
        drive(32'h104, 32'h70, 32'h88, 0, 7, 8, 1, 1, 14, 1, ALU_SUB, 0, 0);
        @(negedge clk);
        check("lu_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1;
        check("lu_bubble_valid", {31'b0, out_valid}, 0);
        check("lu_bubble_sel", {28'b0, out_alu_sel}, {28'b0, ALU_NOP});
        exm_is_load = 0; exm_data = 32'h77;
        issue('{a:32'h77, b:32'h88, rs2:32'h88, pc:32'h104, sel:ALU_SUB, rd:14, wr:1});
        exm_reg_write = 0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure then flush
        out_ready = 1'b0;
        x = '{a:32'h1234, b:32'h5, rs2:32'h0, pc:32'h200, sel:ALU_SUB, rd:9, wr:1};
        drive(32'h200, 32'h1234, 0, 32'h5, 2, 0, 1, 0, 9, 1, ALU_SUB, 0, 1);
        issue(x);
        drive(32'h300, 32'h9, 32'h9, 32'h9, 3, 4, 1, 1, 15, 1, ALU_AND, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", {31'b0, in_ready}, 0);
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_a", out_a, x.a);
            check("hold_b", out_b, x.b);
            check("hold_pc", out_pc, x.pc);
            check("hold_sel", {28'b0, out_alu_sel}, {28'b0, x.sel});
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 0);
        check("flush_sel", {28'b0, out_alu_sel}, {28'b0, ALU_NOP});
        check("flush_reg_write", {31'b0, out_reg_write}, 0);
        void'(sb_q.pop_back());   // held instruction was squashed, never consumed
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_flush_valid", {31'b0, out_valid}, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
